// File: rtl/obi_data_responder.sv
// obi_data_responder: accepts one CPU data request at a time on the
// req/gnt/rvalid port. It replays the request as a held valid/ready
// transaction on the peripheral bus, and answers with a one-cycle rvalid
// pulse. A watchdog aborts transactions that no peripheral answers.
module obi_data_responder #(
  parameter int unsigned TIMEOUT  = 256,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic        clk,
  input  logic        reset,
  // CPU side
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  // Peripheral side
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Last counter value before the watchdog fires. A TIMEOUT of zero disables
  // the watchdog, and the value is then unused.
  localparam int unsigned          TIMEOUT_M1 = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CNT_BITS-1:0]  CNT_LAST   = CNT_BITS'(TIMEOUT_M1);
  localparam logic [CNT_BITS-1:0]  CNT_MAX    = '1;
  localparam bit                   TMO_EN     = (TIMEOUT != 0);

  state_e              state_q, state_d;
  logic [31:0]         addr_q,  addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic                we_q,    we_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q,   err_d;
  logic [CNT_BITS-1:0] cnt_q,   cnt_d;
  logic                accept;

  // Next-state logic: request acceptance, downstream completion and watchdog.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;

    case (state_q)
      IDLE: begin
        accept = req_i;
      end
      BUSY: begin
        // A completion in the same cycle as the timeout takes priority.
        if (mem_ready) begin
          rdata_d = we_q ? 32'h0 : mem_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (TMO_EN && (cnt_q == CNT_LAST)) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        accept  = req_i;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The downstream bus only ever sees these latched copies, so the CPU
    // is free to change its request fields right after the grant.
    if (accept) begin
      addr_d  = addr_i;
      wdata_d = wdata_i;
      we_d    = we_i;
      wstrb_d = we_i ? be_i : 4'b0000;
      cnt_d   = '0;
      state_d = BUSY;
    end
  end

  // State and request/response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'b0000;
      we_q    <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_o     = accept & ~reset;
  assign mem_valid = (state_q == BUSY);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign rvalid_o  = (state_q == RESP);
  assign rdata_o   = rvalid_o ? rdata_q : 32'h0;
  assign err_o     = rvalid_o & err_q;

endmodule
